// File: rtl/rate_sched.sv
// rate_sched: run/pause/clear scheduler that issues counter-step requests at
// one of two selectable rates, with a level request/acknowledge handshake and a
// sticky overrun flag for ticks that arrive while a request is still pending.
module rate_sched #(
  parameter int SLOW_DIV = 500000,
  parameter int FAST_DIV = 10000,
  parameter int DIV_W    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_switch,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clr_btn,
  input  logic       tick_ack,
  output logic       tick_req,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  // Terminal divider values, pre-sized so the compare is width-exact.
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic             r_cnt_clr;
  logic [DIV_W-1:0] r_div;
  logic             r_tick_req;
  logic             r_overrun;

  state_t           w_state_nxt;
  logic             w_spd_chg;
  logic [DIV_W-1:0] w_div_last;
  logic             w_counting;
  logic             w_tick;

  // Two-flop synchronizer for the asynchronous speed switch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sw_switch;
      r_sync2 <= r_sync1;
    end
  end

  // The synchronized speed is about to change at this edge: the divider
  // restarts from 0 under the new period and this cycle never ticks, so the
  // old count is never compared against the new (possibly smaller) limit.
  assign w_spd_chg  = r_sync1 ^ r_sync2;
  assign w_div_last = r_sync2 ? FAST_LAST : SLOW_LAST;

  // Next-state decode: clear beats stop beats start; CLEAR lasts one cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR) begin
      w_state_nxt = ST_IDLE;
    end else if (clr_btn) begin
      w_state_nxt = ST_CLEAR;
    end else if (stop_btn) begin
      if (r_state == ST_RUN) w_state_nxt = ST_PAUSE;
    end else if (start_btn) begin
      if (r_state == ST_IDLE || r_state == ST_PAUSE) w_state_nxt = ST_RUN;
    end
  end

  // The divider advances only while staying in RUN; a stop cycle already holds.
  assign w_counting = (r_state == ST_RUN) && (w_state_nxt == ST_RUN) && !w_spd_chg;
  assign w_tick     = w_counting && (r_div == w_div_last);

  // FSM state register with the registered clear strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt_clr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_clr <= (w_state_nxt == ST_CLEAR);
    end
  end

  // Rate divider: 0..DIV-1 in RUN, held in PAUSE, zero in IDLE/CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_state_nxt == ST_CLEAR || w_state_nxt == ST_IDLE) begin
      r_div <= '0;
    end else if (w_spd_chg) begin
      r_div <= '0;
    end else if (w_counting) begin
      r_div <= (r_div == w_div_last) ? '0 : r_div + 1'b1;
    end
  end

  // Request/acknowledge handshake and sticky overrun detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_req <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_state_nxt == ST_CLEAR) begin
      r_tick_req <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_tick) begin
      // A new tick keeps the request up; it is lost only if the pending one
      // is not being acknowledged in this same cycle.
      r_tick_req <= 1'b1;
      if (r_tick_req && !tick_ack) r_overrun <= 1'b1;
    end else if (r_tick_req && tick_ack) begin
      r_tick_req <= 1'b0;
    end
  end

  assign tick_req = r_tick_req;
  assign cnt_clr  = r_cnt_clr;
  assign state    = r_state;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_rate_sched.sv
// tb_rate_sched: directed scenarios for rate_sched with SLOW_DIV=8, FAST_DIV=3.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_rate_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_switch;
  logic       start_btn;
  logic       stop_btn;
  logic       clr_btn;
  logic       tick_ack;
  logic       tick_req;
  logic       cnt_clr;
  logic [1:0] state;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;

  rate_sched #(
    .SLOW_DIV(8),
    .FAST_DIV(3),
    .DIV_W   (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .sw_switch(sw_switch),
    .start_btn(start_btn),
    .stop_btn (stop_btn),
    .clr_btn  (clr_btn),
    .tick_ack (tick_ack),
    .tick_req (tick_req),
    .cnt_clr  (cnt_clr),
    .state    (state),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until tick_req is seen high, bounded so a dead DUT cannot hang us.
  task automatic wait_rise(output int n);
    n = 0;
    while (!tick_req && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic ack_once();
    tick_ack = 1'b1;
    step();
    tick_ack = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int st, input int req, input int clr, input int ovr);
    chk({tag, "_state"},   int'(state),    st);
    chk({tag, "_req"},     int'(tick_req), req);
    chk({tag, "_cnt_clr"}, int'(cnt_clr),  clr);
    chk({tag, "_overrun"}, int'(overrun),  ovr);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; sw_switch = 1'b0; start_btn = 1'b0; stop_btn = 1'b0;
    clr_btn = 1'b0; tick_ack = 1'b0;

    // Reset values.
    step(); step();
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk("idle_after_rst", int'(state), 0);

    // Slow run with every request acked: first rise in the 9th cycle after the
    // cycle presenting start (8 edges after the start edge), then every 8.
    start_btn = 1'b1; step(); start_btn = 1'b0;
    chk("s1_state_run", int'(state), 1);
    wait_rise(n);
    chk("s1_first_rise", n, 8);
    for (int i = 0; i < 2; i++) begin
      ack_once();
      chk("s1_ack_clears", int'(tick_req), 0);
      wait_rise(n);
      chk("s1_period", n + 1, 8);
    end
    chk("s1_no_overrun", int'(overrun), 0);

    // Pause at divider=5 for 20 cycles, resume: 5,6,7 then the request.
    ack_once();                 // divider 1
    repeat (4) step();          // divider 5
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    chk("s2_paused", int'(state), 2);
    seen = 0;
    repeat (20) begin
      step();
      if (tick_req) seen = 1;
    end
    chk("s2_no_tick_in_pause", seen, 0);
    chk("s2_still_paused", int'(state), 2);
    start_btn = 1'b1; step(); start_btn = 1'b0;
    chk("s2_resumed", int'(state), 1);
    wait_rise(n);
    chk("s2_resume_rise", n, 3);

    // Slow divider at 6, switch to fast: divider goes 7 (no tick while the
    // change is in flight), 0, 1, 2 -> request 5 edges after the switch.
    ack_once();                 // divider 1
    repeat (5) step();          // divider 6
    sw_switch = 1'b1;
    wait_rise(n);
    chk("s3_switch_rise", n, 5);
    for (int i = 0; i < 2; i++) begin
      ack_once();
      wait_rise(n);
      chk("s3_fast_period", n + 1, 3);
    end

    // Tick and ack in the same cycle: request stays up, no overrun.
    step(); step();             // tick-event cycle, request still pending
    ack_once();
    chk("same_cycle_req", int'(tick_req), 1);
    chk("same_cycle_ovr", int'(overrun), 0);

    // No acks for two periods: overrun sets on the second event, then clear.
    ack_once();
    chk("s4_req_dropped", int'(tick_req), 0);
    step(); step();
    chk("s4_first_event_req", int'(tick_req), 1);
    chk("s4_first_event_ovr", int'(overrun), 0);
    step(); step();
    chk("s4_before_second", int'(overrun), 0);
    step();
    chk("s4_overrun_set", int'(overrun), 1);
    chk("s4_req_held", int'(tick_req), 1);
    repeat (3) step();
    chk("s4_overrun_sticky", int'(overrun), 1);
    clr_btn = 1'b1; step(); clr_btn = 1'b0;
    chk_all("s4_clear", 3, 0, 1, 0);
    step();
    chk_all("s4_idle", 0, 0, 0, 0);

    // start, stop and clr together from RUN: clear wins.
    start_btn = 1'b1; step(); start_btn = 1'b0;
    chk("s5_run", int'(state), 1);
    start_btn = 1'b1; stop_btn = 1'b1; clr_btn = 1'b1;
    step();
    start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0;
    chk("s5_clear", int'(state), 3);
    chk("s5_cnt_clr", int'(cnt_clr), 1);
    step();
    chk("s5_idle", int'(state), 0);

    // Reset mid-RUN with a pending request and overrun; start ignored in reset.
    start_btn = 1'b1; step(); start_btn = 1'b0;
    wait_rise(n);
    chk("s6_rise_from_clear", n, 3);
    repeat (4) step();
    chk("s6_overrun_pre", int'(overrun), 1);
    rst = 1'b1; start_btn = 1'b1;
    step();
    chk_all("s6_reset", 0, 0, 0, 0);
    step();
    chk("s6_start_ignored", int'(state), 0);
    rst = 1'b0; start_btn = 1'b0;
    step();
    chk_all("s6_after", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rate_sched.md
RATE_SCHED -- requirements
Module: rate_sched

Interface
REQ-001 Parameter SLOW_DIV, default 500000: tick period in clk cycles when speed select = 0.
REQ-002 Parameter FAST_DIV, default 10000: tick period in clk cycles when speed select = 1.
REQ-003 Parameter DIV_W, default 20: divider counter width; SHALL satisfy 2^DIV_W > max(SLOW_DIV, FAST_DIV).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sw_switch  input  1  asynchronous speed select: 0 = slow, 1 = fast.
REQ-007 start_btn  input  1  one-cycle start/resume pulse, already debounced and synchronous to clk.
REQ-008 stop_btn  input  1  one-cycle pause pulse, already debounced and synchronous to clk.
REQ-009 clr_btn  input  1  one-cycle clear pulse, already debounced and synchronous to clk.
REQ-010 tick_ack  input  1  consumer acknowledge of tick_req.
REQ-011 tick_req  output  1  level request: one counter step pending.
REQ-012 cnt_clr  output  1  one-cycle clear strobe to the counter datapath.
REQ-013 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, CLEAR=11.
REQ-014 overrun  output  1  sticky flag: a tick was lost.

Function
REQ-015 sw_switch SHALL pass through a 2-flop synchronizer; only the synchronized value (spd) is used.
REQ-016 The FSM SHALL have states IDLE, RUN, PAUSE and CLEAR, encoded as in REQ-013.
REQ-017 Input priority in any state: clr_btn > stop_btn > start_btn.
REQ-018 Transitions:
- IDLE: start -> RUN.
- RUN: stop -> PAUSE.
- PAUSE: start -> RUN.
- Any state: clr -> CLEAR.
- CLEAR -> IDLE unconditionally after 1 cycle.
REQ-019 cnt_clr SHALL be 1 exactly during the CLEAR cycle.
REQ-020 Divider DIV = spd ? FAST_DIV : SLOW_DIV.
REQ-021 In RUN, the divider counts 0..DIV-1 and wraps to 0; the tick event fires on the cycle the divider equals DIV-1, giving exactly DIV cycles between events.
REQ-022 In PAUSE, the divider SHALL hold its value; on resume, counting continues from the held value.
REQ-023 In IDLE and CLEAR, the divider SHALL be 0.
REQ-024 A change of spd SHALL reset the divider to 0 on the following cycle, with no tick event in that cycle; the new period applies from 0.
REQ-025 If the divider exceeds the new DIV-1 when spd changes, REQ-024 governs; no out-of-range compare is permitted.
REQ-026 A tick event SHALL set tick_req to 1 on the next cycle.
REQ-027 tick_req SHALL clear on the cycle after tick_ack=1 is sampled while tick_req=1.
REQ-028 tick_ack with tick_req=0 SHALL be ignored.
REQ-029 On a tick event while tick_req=1 and no ack in the same cycle, tick_req stays 1 and overrun sets.
REQ-030 On a tick event and an ack in the same cycle, tick_req stays 1 and overrun does not set.
REQ-031 overrun SHALL clear only on CLEAR or rst.
REQ-032 Entering CLEAR SHALL drop tick_req to 0.
REQ-033 In PAUSE, tick_req is retained and the ack handshake still works.

Reset
REQ-034 On rst=1 at a clk edge, the block SHALL reset to:
- state=IDLE, divider=0, tick_req=0, cnt_clr=0, overrun=0.
- Synchronizer flops = 0.
REQ-035 rst SHALL take priority over every input, including mid-RUN with tick_req pending.

Verification (SLOW_DIV=8, FAST_DIV=3)
REQ-036 Scenario: rst, sw=0, start; ack every tick_req -> tick_req rises every 8 cycles; first rise 9 cycles after the start sample.
REQ-037 Scenario: RUN at divider=5, stop; wait 20 cycles; start -> no tick during PAUSE; next tick 3 counting cycles after resume.
REQ-038 Scenario: RUN slow at divider=6, sw 0->1 -> divider 0 two sync cycles later; ticks then every 3 cycles; no spurious tick.
REQ-039 Scenario: never ack for 2 tick periods -> tick_req held at 1, overrun=1 after the second event; then clr -> cnt_clr pulse, tick_req=0, overrun=0, state 11 then 00.
REQ-040 Scenario: start, stop and clr in the same cycle from RUN -> state=CLEAR next cycle, then IDLE.
REQ-041 Scenario: rst asserted mid-RUN with tick_req=1 -> all outputs at reset values next cycle; start is ignored while rst=1.
